// File: rtl/pe.sv
// Systolic-array processing element.
// Each PE holds an 8-bit signed weight, multiplies it by the incoming
// activation, and adds the product to a partial sum that arrives in
// carry-save form. The result also leaves in carry-save form, so no carry
// chain runs through the array. The cpa companion resolves the two words
// at the edge of the array.
//
// The parameter 'size' is the number of psum guard bits. Keep it even and
// at least 2. The psum width is W = size + 16.

// Final carry-propagate adder that resolves a carry-save pair into one word.
module cpa #(
   parameter int N = 20
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N:0]   out
);

   // Unsigned add with the carry kept in the top bit.
   always_comb begin
      out = {1'b0, a} + {1'b0, b};
   end

endmodule

module pe #(
   parameter int size = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             preclk,
   input  logic [7:0]       weight,
   input  logic [7:0]       in,
   input  logic [size+15:0] psum0,
   input  logic [size+15:0] psum1,
   output logic [7:0]       weightO,
   output logic [7:0]       inO,
   output logic [size+15:0] psumO0,
   output logic [size+15:0] psumO1
);

   localparam int W = size + 16;

   logic [7:0]   weight_q, weight_d;
   logic [7:0]   in_q, in_d;
   logic [W-1:0] psum0_q, psum0_d;
   logic [W-1:0] psum1_q, psum1_d;

   logic [W-1:0] mcand;
   logic [W-1:0] mcand2;
   logic [8:0]   mplier;
   logic [W-1:0] pp [4];
   logic [W-1:0] boothCorr;

   logic [W-1:0] s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

   // 3:2 compressor sum bit. All operands wrap modulo 2^W.
   function automatic logic [W-1:0] csaSum(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
      return a ^ b ^ c;
   endfunction

   // 3:2 compressor carry bit. It moves up one place, and the carry out of
   // the MSB is dropped because the arithmetic is modulo 2^W.
   function automatic logic [W-1:0] csaCarry(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
      return ((a & b) | (a & c) | (b & c)) << 1;
   endfunction

   // Radix-4 Booth recoding of the activation against the stored weight.
   // A negative digit uses the inverted multiple. Its +1 at bit 2i is
   // collected in boothCorr. Those bits never overlap, so a single extra
   // operand carries all four of them.
   always_comb begin
      mcand     = {{(W-8){weight_q[7]}}, weight_q};
      mcand2    = mcand << 1;
      mplier    = {in, 1'b0};
      boothCorr = '0;
      for (int i = 0; i < 4; i++) begin
         pp[i] = '0;
         case (mplier[2*i +: 3])
            3'b001, 3'b010: pp[i] = mcand << (2*i);
            3'b011:         pp[i] = mcand2 << (2*i);
            3'b100: begin
               pp[i]          = (~mcand2) << (2*i);
               boothCorr[2*i] = 1'b1;
            end
            3'b101, 3'b110: begin
               pp[i]          = (~mcand) << (2*i);
               boothCorr[2*i] = 1'b1;
            end
            default:        pp[i] = '0;
         endcase
      end
   end

   // Wallace-style 3:2 tree. It reduces seven operands to two: four partial
   // products, the Booth correction word, and both incoming psum words.
   assign s1 = csaSum  (pp[0], pp[1], pp[2]);
   assign c1 = csaCarry(pp[0], pp[1], pp[2]);
   assign s2 = csaSum  (pp[3], boothCorr, psum0);
   assign c2 = csaCarry(pp[3], boothCorr, psum0);
   assign s3 = csaSum  (s1, c1, s2);
   assign c3 = csaCarry(s1, c1, s2);
   assign s4 = csaSum  (s3, c3, c2);
   assign c4 = csaCarry(s3, c3, c2);
   assign s5 = csaSum  (s4, c4, psum1);
   assign c5 = csaCarry(s4, c4, psum1);

   // Next-state selection: the weight loads only when preclk is high.
   // The activation and the carry-save result advance every cycle.
   always_comb begin
      weight_d = preclk ? weight : weight_q;
      in_d     = in;
      psum0_d  = s5;
      psum1_d  = c5;
   end

   // Pipeline registers. Reset clears both the stored weight and any
   // pending result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         weight_q <= '0;
         in_q     <= '0;
         psum0_q  <= '0;
         psum1_q  <= '0;
      end else begin
         weight_q <= weight_d;
         in_q     <= in_d;
         psum0_q  <= psum0_d;
         psum1_q  <= psum1_d;
      end
   end

   assign weightO = weight_q;
   assign inO     = in_q;
   assign psumO0  = psum0_q;
   assign psumO1  = psum1_q;

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe (size=4, W=20) with the cpa resolver attached.
// The reference model keeps the stored weight as a plain variable. It
// computes each result as w*in + psum0 + psum1 modulo 2^20 with integer
// arithmetic.
module tb_pe;

   localparam int SIZE = 4;
   localparam int W    = SIZE + 16;

   logic         clk;
   logic         rstn;
   logic         preclk;
   logic [7:0]   weight;
   logic [7:0]   inAct;
   logic [W-1:0] psum0;
   logic [W-1:0] psum1;
   logic [7:0]   weightO;
   logic [7:0]   inO;
   logic [W-1:0] psumO0;
   logic [W-1:0] psumO1;
   logic [W:0]   cpaOut;

   int           assertCount;
   int           failCount;
   logic [7:0]   modelW;

   pe #(.size(SIZE)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .preclk  (preclk),
      .weight  (weight),
      .in      (inAct),
      .psum0   (psum0),
      .psum1   (psum1),
      .weightO (weightO),
      .inO     (inO),
      .psumO0  (psumO0),
      .psumO1  (psumO1)
   );

   cpa #(.N(W)) resolver (
      .a   (psumO0),
      .b   (psumO1),
      .out (cpaOut)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Plain arithmetic reference: the signed product plus both psum words,
   // wrapped to 20 bits.
   function automatic logic [W-1:0] refSum(input logic [7:0] w,
                                           input logic [7:0] a,
                                           input logic [W-1:0] p0,
                                           input logic [W-1:0] p1);
      int         prod;
      logic [31:0] tot;
      prod = int'($signed(w)) * int'($signed(a));
      tot  = 32'(p0) + 32'(p1) + 32'(prod);
      return tot[W-1:0];
   endfunction

   // One comparison: count it, and report a failure with its tag.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs away from the active edge, let the edge
   // happen, then compare the registered outputs against the model.
   task automatic applyStimulus(input string tag, input logic pc,
                                input logic [7:0] w, input logic [7:0] a,
                                input logic [W-1:0] p0, input logic [W-1:0] p1);
      logic [W-1:0] expSum;
      @(negedge clk);
      preclk = pc;
      weight = w;
      inAct  = a;
      psum0  = p0;
      psum1  = p1;
      expSum = refSum(modelW, a, p0, p1);
      @(posedge clk);
      #1;
      if (pc) modelW = w;
      checkOutput({tag, ".sum"},     32'(cpaOut[W-1:0]), 32'(expSum));
      checkOutput({tag, ".inO"},     32'(inO),           32'(a));
      checkOutput({tag, ".weightO"}, 32'(weightO),       32'(modelW));
   endtask

   // Asynchronous reset check: every register must read zero.
   task automatic checkReset(input string tag);
      checkOutput({tag, ".weightO"}, 32'(weightO),        32'h0);
      checkOutput({tag, ".inO"},     32'(inO),            32'h0);
      checkOutput({tag, ".psumO0"},  32'(psumO0),         32'h0);
      checkOutput({tag, ".psumO1"},  32'(psumO1),         32'h0);
      checkOutput({tag, ".sum"},     32'(cpaOut[W-1:0]),  32'h0);
   endtask

   // Directed sequence followed by randomized load/compute pairs.
   initial begin
      assertCount = 0;
      failCount   = 0;
      modelW      = 8'h00;
      rstn        = 1'b0;
      preclk      = 1'b0;
      weight      = 8'h00;
      inAct       = 8'h00;
      psum0       = '0;
      psum1       = '0;

      // Reset held while the inputs toggle, across several clock edges.
      for (int k = 0; k < 3; k++) begin
         #3;
         preclk = 1'b1;
         weight = 8'($urandom);
         inAct  = 8'($urandom);
         psum0  = W'($urandom);
         psum1  = W'($urandom);
         #4;
         checkReset("reset");
      end
      @(negedge clk);
      rstn   = 1'b1;
      modelW = 8'h00;

      // Load 3, then compute 3*5 + 10 + 20.
      applyStimulus("load3",   1'b1, 8'd3, 8'd0, 20'd0,  20'd0);
      applyStimulus("compute", 1'b0, 8'd0, 8'd5, 20'd10, 20'd20);

      // Hold: a different value on the weight port must be ignored.
      applyStimulus("hold", 1'b0, 8'h55, 8'hFD, 20'd7, 20'hFFFF0);
      checkOutput("hold.weight3", 32'(weightO), 32'd3);

      // Signed extremes.
      applyStimulus("ldNeg128", 1'b1, 8'h80, 8'h00, 20'd0, 20'd0);
      applyStimulus("negSq",    1'b0, 8'h00, 8'h80, 20'd0, 20'd0);
      checkOutput("negSq.const", 32'(cpaOut[W-1:0]), 32'h04000);
      applyStimulus("ld127",    1'b1, 8'h7F, 8'h00, 20'd0, 20'd0);
      applyStimulus("maxMin",   1'b0, 8'h00, 8'h80, 20'd0, 20'd0);
      checkOutput("maxMin.const", 32'(cpaOut[W-1:0]), 32'hFC080);

      // Wrap and carry with a zero weight.
      applyStimulus("ldZero", 1'b1, 8'h00, 8'h00, 20'd0, 20'd0);
      applyStimulus("wrapMid", 1'b0, 8'h00, 8'h00, 20'h7FFFF, 20'h00001);
      checkOutput("wrapMid.const", 32'(cpaOut[W-1:0]), 32'h80000);
      applyStimulus("wrapTop", 1'b0, 8'h00, 8'h00, 20'hFFFFF, 20'h00001);
      checkOutput("wrapTop.full", 32'(cpaOut), 32'h100000);

      // Reset in mid-operation drops the weight and the pending result at once.
      applyStimulus("preRstLd",  1'b1, 8'h07, 8'h00, 20'd0,   20'd0);
      applyStimulus("preRstRun", 1'b0, 8'h00, 8'h09, 20'd100, 20'd3);
      #2;
      rstn = 1'b0;
      #1;
      checkReset("midReset");
      @(negedge clk);
      rstn   = 1'b1;
      modelW = 8'h00;
      applyStimulus("postRst", 1'b0, 8'h11, 8'h09, 20'd100, 20'd200);

      // Randomized loads, each followed by a compute cycle.
      for (int n = 0; n < 120; n++) begin
         applyStimulus("rndLoad", 1'b1, 8'($urandom), 8'($urandom),
                       W'($urandom), W'($urandom));
         applyStimulus("rndRun", 1'($urandom), 8'($urandom), 8'($urandom),
                       W'($urandom), W'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
